xdma_cfg_deframer: RTL

- Receives the inter-cluster config frame stream (one DataWidth word per frame) arriving at the FromRemoteCfg decoder output.
- Reassembles a multi-frame config (first frame plus frame_length-1 continuation frames) into one wide descriptor for the local xDMA.
- Generalises the fixed single-frame config: MaxFrames, widths and a collection watchdog are parameters.
- Adds frame-consistency checking and error reporting.

---
 rtl/xdma_pkg.sv | 58 +++++
 rtl/xdma_cfg_deframer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/xdma_pkg.sv
// Shared definitions for the xDMA config-frame deframer: frame field offsets,
// error codes, FSM states and the default-width deframed header record.
package xdma_pkg;

  localparam int XDMA_DATA_W  = 512;
  localparam int XDMA_ADDR_W  = 48;
  localparam int XDMA_ID_W    = 4;
  localparam int XDMA_FLEN_W  = 4;

  typedef enum logic [1:0] {
    XDMA_ERR_NONE     = 2'd0,
    XDMA_ERR_BAD_LEN  = 2'd1,
    XDMA_ERR_MISMATCH = 2'd2,
    XDMA_ERR_TIMEOUT  = 2'd3
  } xdma_cfg_err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } xdma_dfr_state_e;

  // First frame, LSB up: dma_type, frame_length, dma_id, reader, writer, payload.
  function automatic int first_id_lo(input int flen_w);
    return 1 + flen_w;
  endfunction

  function automatic int first_raddr_lo(input int flen_w, input int id_w);
    return 1 + flen_w + id_w;
  endfunction

  function automatic int first_waddr_lo(input int flen_w, input int id_w, input int addr_w);
    return 1 + flen_w + id_w + addr_w;
  endfunction

  function automatic int first_pay_lo(input int flen_w, input int id_w, input int addr_w);
    return 1 + flen_w + id_w + 2 * addr_w;
  endfunction

  // Continuation frame, LSB up: dma_id, dma_type, payload.
  function automatic int cont_type_bit(input int id_w);
    return id_w;
  endfunction

  function automatic int cont_pay_lo(input int id_w);
    return id_w + 1;
  endfunction

  typedef struct packed {
    logic [XDMA_ID_W-1:0]   dma_id;
    logic                   dma_type;
    logic [XDMA_ADDR_W-1:0] reader_addr;
    logic [XDMA_ADDR_W-1:0] writer_addr;
    logic [XDMA_FLEN_W-1:0] num_frames;
  } xdma_deframed_cfg_t;

endpackage

// File: rtl/xdma_cfg_deframer.sv
// Reassembles a multi-frame inter-cluster config stream into one wide xDMA
// descriptor, with length/consistency checks and a collection watchdog.
module xdma_cfg_deframer
  import xdma_pkg::*;
#(
  parameter int DataWidth     = 512,
  parameter int AddrWidth     = 48,
  parameter int DMAIdWidth    = 4,
  parameter int FrameLenWidth = 4,
  parameter int MaxFrames     = 8,
  parameter int TimeoutCycles = 1024,
  localparam int FirstPW  = DataWidth - 1 - FrameLenWidth - DMAIdWidth - 2 * AddrWidth,
  localparam int ContPW   = DataWidth - 1 - DMAIdWidth,
  localparam int PayloadW = FirstPW + (MaxFrames - 1) * ContPW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DataWidth-1:0]     frame_i,
  input  logic                     frame_valid_i,
  output logic                     frame_ready_o,
  output logic [DMAIdWidth-1:0]    cfg_dma_id_o,
  output logic                     cfg_dma_type_o,
  output logic [AddrWidth-1:0]     cfg_reader_addr_o,
  output logic [AddrWidth-1:0]     cfg_writer_addr_o,
  output logic [FrameLenWidth-1:0] cfg_num_frames_o,
  output logic [PayloadW-1:0]      cfg_payload_o,
  output logic                     cfg_valid_o,
  input  logic                     cfg_ready_i,
  output logic                     err_valid_o,
  output logic [1:0]               err_code_o,
  output logic [DMAIdWidth-1:0]    err_dma_id_o
);

  localparam int IdLo       = first_id_lo(FrameLenWidth);
  localparam int RaddrLo    = first_raddr_lo(FrameLenWidth, DMAIdWidth);
  localparam int WaddrLo    = first_waddr_lo(FrameLenWidth, DMAIdWidth, AddrWidth);
  localparam int FirstPayLo = first_pay_lo(FrameLenWidth, DMAIdWidth, AddrWidth);
  localparam int CTypeBit   = cont_type_bit(DMAIdWidth);
  localparam int ContPayLo  = cont_pay_lo(DMAIdWidth);
  localparam int WdW        = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [FrameLenWidth-1:0] MaxLen = FrameLenWidth'(MaxFrames);
  localparam logic [FrameLenWidth-1:0] OneLen = FrameLenWidth'(1);

  xdma_dfr_state_e           state_q, state_d;
  logic [DMAIdWidth-1:0]     id_q, id_d;
  logic                      type_q, type_d;
  logic [AddrWidth-1:0]      raddr_q, raddr_d, waddr_q, waddr_d;
  logic [FrameLenWidth-1:0]  len_q, len_d, cnt_q, cnt_d, remain_q, remain_d;
  logic [PayloadW-1:0]       payload_q, payload_d;
  logic [WdW-1:0]            wdog_q, wdog_d;
  logic                      err_valid_q, err_valid_d;
  xdma_cfg_err_e             err_code_q, err_code_d;
  logic [DMAIdWidth-1:0]     err_id_q, err_id_d;

  logic                      frame_hs;
  logic                      f_type, f_ctype;
  logic [FrameLenWidth-1:0]  f_len;
  logic [DMAIdWidth-1:0]     f_id, f_cid;
  logic [AddrWidth-1:0]      f_raddr, f_waddr;
  logic [FirstPW-1:0]        f_first_pay;
  logic [ContPW-1:0]         f_cont_pay;

  assign f_type      = frame_i[0];
  assign f_len       = frame_i[FrameLenWidth:1];
  assign f_id        = frame_i[IdLo +: DMAIdWidth];
  assign f_raddr     = frame_i[RaddrLo +: AddrWidth];
  assign f_waddr     = frame_i[WaddrLo +: AddrWidth];
  assign f_first_pay = frame_i[FirstPayLo +: FirstPW];
  assign f_cid       = frame_i[DMAIdWidth-1:0];
  assign f_ctype     = frame_i[CTypeBit];
  assign f_cont_pay  = frame_i[ContPayLo +: ContPW];

  assign frame_ready_o = (state_q != ST_EMIT);
  assign frame_hs      = frame_valid_i & frame_ready_o;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    type_d      = type_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    remain_d    = remain_q;
    payload_d   = payload_q;
    wdog_d      = wdog_q;
    err_valid_d = 1'b0;
    err_code_d  = XDMA_ERR_NONE;
    err_id_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (frame_hs) begin
          id_d      = f_id;
          type_d    = f_type;
          raddr_d   = f_raddr;
          waddr_d   = f_waddr;
          len_d     = f_len;
          cnt_d     = OneLen;
          wdog_d    = '0;
          payload_d = '0;
          payload_d[FirstPW-1:0] = f_first_pay;
          if (f_len == '0) begin
            err_valid_d = 1'b1;
            err_code_d  = XDMA_ERR_BAD_LEN;
            err_id_d    = f_id;
          end else if (f_len == OneLen) begin
            state_d = ST_EMIT;
          end else if (f_len <= MaxLen) begin
            state_d = ST_COLLECT;
          end else begin
            // Oversized config: swallow its continuation frames silently.
            err_valid_d = 1'b1;
            err_code_d  = XDMA_ERR_BAD_LEN;
            err_id_d    = f_id;
            remain_d    = f_len - OneLen;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_COLLECT: begin
        if (frame_hs) begin
          wdog_d = '0;
          if (f_cid == id_q && f_ctype == type_q) begin
            for (int s = 1; s < MaxFrames; s++) begin
              if (cnt_q == FrameLenWidth'(s))
                payload_d[FirstPW + (s - 1) * ContPW +: ContPW] = f_cont_pay;
            end
            cnt_d = cnt_q + OneLen;
            if (cnt_d == len_q) state_d = ST_EMIT;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = XDMA_ERR_MISMATCH;
            err_id_d    = id_q;
            state_d     = ST_IDLE;
          end
        end else if (TimeoutCycles > 0) begin
          wdog_d = wdog_q + WdW'(1);
          if (wdog_d == WdW'(TimeoutCycles)) begin
            err_valid_d = 1'b1;
            err_code_d  = XDMA_ERR_TIMEOUT;
            err_id_d    = id_q;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        if (cfg_ready_i) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (frame_hs) begin
          remain_d = remain_q - OneLen;
          if (remain_q == OneLen) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      id_q        <= '0;
      type_q      <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      remain_q    <= '0;
      payload_q   <= '0;
      wdog_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= XDMA_ERR_NONE;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      type_q      <= type_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      remain_q    <= remain_d;
      payload_q   <= payload_d;
      wdog_q      <= wdog_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_id_q    <= err_id_d;
    end
  end

  assign cfg_valid_o       = (state_q == ST_EMIT);
  assign cfg_dma_id_o      = id_q;
  assign cfg_dma_type_o    = type_q;
  assign cfg_reader_addr_o = raddr_q;
  assign cfg_writer_addr_o = waddr_q;
  assign cfg_num_frames_o  = cnt_q;
  assign cfg_payload_o     = payload_q;
  assign err_valid_o       = err_valid_q;
  assign err_code_o        = err_code_q;
  assign err_dma_id_o      = err_id_q;

endmodule
